// File: rtl/aes_inv_key_sched_if.sv
// Handshake/bus bundle between the key register side and the inverse key schedule.
interface aes_inv_key_sched_if;
  logic         kld;
  logic [127:0] key_in;
  logic         adv;
  logic [127:0] rkey;
  logic [3:0]   rnd;
  logic         kvld;
  logic         done;

  modport master (output kld, key_in, adv, input rkey, rnd, kvld, done);
  modport slave  (input kld, key_in, adv, output rkey, rnd, kvld, done);
endinterface

// File: rtl/aes_inv_key_sched.sv
// Reverse AES-128 key schedule: loaded with the round 10 key, each advance
// steps back one round key until the cipher key (round 0) is reached.

// Forward AES S-box, computed as GF(2^8) inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign d = affine(gf_inv(a));
endmodule

module aes_inv_key_sched (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_key_sched_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot, sub;

  // Descending round constant for stepping from round r back to r-1.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd10:   return 8'h36;
      4'd9:    return 8'h1b;
      4'd8:    return 8'h80;
      4'd7:    return 8'h40;
      4'd6:    return 8'h20;
      4'd5:    return 8'h10;
      4'd4:    return 8'h08;
      4'd3:    return 8'h04;
      4'd2:    return 8'h02;
      4'd1:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = bus.rkey;

  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .d(sub[8*i +: 8]));
  end

  assign p0 = w0 ^ sub ^ {rcon(bus.rnd), 24'h000000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bus.rkey <= '0;
      bus.rnd  <= '0;
      bus.kvld <= 1'b0;
      bus.done <= 1'b0;
    end else if (bus.kld) begin
      // A load wins over a same-cycle advance and discards any walk in progress.
      state    <= RUN;
      bus.rkey <= bus.key_in;
      bus.rnd  <= 4'd10;
      bus.kvld <= 1'b1;
      bus.done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.adv) begin
            bus.rkey <= {p0, p1, p2, p3};
            bus.rnd  <= bus.rnd - 4'd1;
            if (bus.rnd == 4'd1) begin
              state    <= FIN;
              bus.done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
